// File: rtl/bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// bcd_serial_addsub
//
// Multi-digit BCD adder/subtractor. It processes one decimal digit per clock,
// starting with the least significant digit, and uses a start/busy/done
// handshake.
//
// Each digit is computed with a 4-bit binary add. A +6 correction is applied
// when the 5-bit sum exceeds 9. For subtraction, the nine's complement of B is
// used and the carry chain starts at 1, which produces a ten's-complement
// result.
//
// Parameters
//   DIGITS   number of BCD digits per operand/result (DIGITS >= 1)
//
// Ports
//   clk      in   1         clock, rising edge
//   rst      in   1         asynchronous, active-high reset
//   start    in   1         request, sampled only in IDLE or DONE
//   sub      in   1         0: a+b, 1: a-b (latched with start)
//   a        in   4*DIGITS  operand A, digit k = a[4k+3:4k] (latched with start)
//   b        in   4*DIGITS  operand B, same layout (latched with start)
//   busy     out  1         high while digits are being processed
//   done     out  1         one-cycle pulse: sum/cout/invalid are final
//   sum      out  4*DIGITS  BCD result, held until the next accepted start
//   cout     out  1         add: decimal overflow; sub: 1 = no borrow (a>=b)
//   invalid  out  1         some latched digit of a or b was greater than 9
// -----------------------------------------------------------------------------
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             invalid_q;

  // Operands latched on the accept edge
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;

  // Per-digit datapath signals for the digit currently selected by idx_q
  logic             accept;
  logic [3:0]       a_dig;
  logic [3:0]       b_dig;
  logic [3:0]       b_eff;
  logic [4:0]       t_sum;
  logic             dc_d;
  logic [3:0]       sum_dig_d;

  // Returns 1 if any 4-bit digit of v is outside the range 0..9.
  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic flag;
    flag = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) flag = 1'b1;
    end
    return flag;
  endfunction

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    a_dig     = a_q[4*idx_q +: 4];
    b_dig     = b_q[4*idx_q +: 4];
    // The nine's complement of B wraps in 4 bits, so non-BCD digits stay deterministic.
    b_eff     = sub_q ? (4'd9 - b_dig) : b_dig;
    t_sum     = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    dc_d      = (t_sum > 5'd9);
    sum_dig_d = dc_d ? (t_sum[3:0] + 4'd6) : t_sum[3:0];
  end

  // NOTE: the operand registers carry no reset. They are only read after an accept edge
  // has loaded them, and keeping them out of the reset block avoids a reset-gated enable.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            // Subtraction seeds the chain with 1: nine's complement + 1 = ten's complement.
            carry_q   <= sub;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= has_non_bcd(a) | has_non_bcd(b);
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        S_RUN: begin
          sum_q[4*idx_q +: 4] <= sum_dig_d;
          carry_q             <= dc_d;
          if (idx_q == LAST_IDX) begin
            cout_q  <= dc_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_addsub
//
// Directed testbench for bcd_serial_addsub with DIGITS=4. It applies hand-worked
// vectors covering addition, subtraction, the carry ripple, non-BCD inputs,
// start ignored while busy, asynchronous reset in RUN, and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int checks   = 0;
  int failures = 0;
  int edges;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and hold start for exactly one accept edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    a     = av;
    b     = bv;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen. The wait is bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'h0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_invalid", 32'(invalid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1234 + 8766 = 10000 -> 0000 with decimal overflow
    start_op(16'h1234, 16'h8766, 1'b0);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    check("t1_sum_cleared", 32'(sum), 32'h0);
    tick();
    check("t1_first_digit_only", 32'(sum), 32'h0000);
    wait_done(edges);
    // 1 edge already taken in RUN, accept edge + 4 RUN edges = 5 edges to done
    check("t1_latency_edges", 32'(edges + 2), 32'd5);
    check("t1_sum", 32'(sum), 32'h0000);
    check("t1_cout", 32'(cout), 32'd1);
    check("t1_invalid", 32'(invalid), 32'd0);
    check("t1_busy_in_done", 32'(busy), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_sum_held", 32'(sum), 32'h0000);

    // 5000 - 0001 = 4999, no borrow
    start_op(16'h5000, 16'h0001, 1'b1);
    wait_done(edges);
    check("t2a_latency_edges", 32'(edges), 32'd4);
    check("t2a_sum", 32'(sum), 32'h4999);
    check("t2a_cout", 32'(cout), 32'd1);
    tick();

    // 0001 - 0002 = -1 -> ten's complement 9999 with borrow
    start_op(16'h0001, 16'h0002, 1'b1);
    wait_done(edges);
    check("t2b_sum", 32'(sum), 32'h9999);
    check("t2b_cout", 32'(cout), 32'd0);
    tick();

    // 0999 + 0001 = 1000, carry ripples across three digits
    start_op(16'h0999, 16'h0001, 1'b0);
    wait_done(edges);
    check("t3a_sum", 32'(sum), 32'h1000);
    check("t3a_cout", 32'(cout), 32'd0);
    tick();

    // 9999 + 9999 = 19998
    start_op(16'h9999, 16'h9999, 1'b0);
    wait_done(edges);
    check("t3b_sum", 32'(sum), 32'h9998);
    check("t3b_cout", 32'(cout), 32'd1);
    tick();

    // Non-BCD digit: digit1 = A + 0 = 10 -> 0 with carry, so sum = 0104
    start_op(16'h00A3, 16'h0001, 1'b0);
    wait_done(edges);
    check("t4_invalid", 32'(invalid), 32'd1);
    check("t4_sum", 32'(sum), 32'h0104);
    check("t4_cout", 32'(cout), 32'd0);
    tick();
    check("t4_invalid_held", 32'(invalid), 32'd1);
    start_op(16'h0012, 16'h0034, 1'b0);
    wait_done(edges);
    check("t4_invalid_cleared", 32'(invalid), 32'd0);
    check("t4_next_sum", 32'(sum), 32'h0046);
    tick();

    // A start pulse in RUN with other operands must be ignored
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();
    a     = 16'h9999;
    b     = 16'h9999;
    sub   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(edges);
    check("t5_latency_edges", 32'(edges), 32'd2);
    check("t5_sum", 32'(sum), 32'h3333);
    check("t5_cout", 32'(cout), 32'd0);
    tick();
    check("t5_back_to_idle", 32'(busy), 32'd0);
    check("t5_no_second_done", 32'(done), 32'd0);

    // Asynchronous reset in RUN, applied between edges
    start_op(16'h1234, 16'h1111, 1'b0);
    tick();
    tick();
    check("t6_partial_sum", 32'(sum), 32'h0045);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_sum", 32'(sum), 32'h0);
    check("t6_rst_cout", 32'(cout), 32'd0);
    #1 rst = 1'b0;
    tick();
    check("t6_idle_after_rst", 32'(busy), 32'd0);

    // Back-to-back: start held during the DONE cycle is accepted immediately
    start_op(16'h0005, 16'h0004, 1'b0);
    wait_done(edges);
    check("t6b_first_sum", 32'(sum), 32'h0009);
    a     = 16'h0100;
    b     = 16'h0200;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6b_busy_next", 32'(busy), 32'd1);
    check("t6b_done_not_extended", 32'(done), 32'd0);
    check("t6b_sum_cleared", 32'(sum), 32'h0);
    wait_done(edges);
    check("t6b_latency_edges", 32'(edges), 32'd4);
    check("t6b_second_sum", 32'(sum), 32'h0300);
    check("t6b_second_cout", 32'(cout), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
